// File: rtl/imem_port_arb.sv
// rtl/imem_port_arb.sv - two-requester arbiter (CPU fetch, host loader) for the single-port instruction memory
// Define IMEM_ARB_RR_EN for round-robin arbitration; the default is loader priority with a fetch starvation guard.
module imem_port_arb #(
    parameter int AW       = 16,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,

    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,

    output logic [AW-1:0] m_addr,
    output logic          m_we,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    logic loader_wins;
    logic l_rd_gnt;

`ifdef IMEM_ARB_RR_EN
    typedef enum logic {
        SRC_FETCH  = 1'b0,
        SRC_LOADER = 1'b1
    } src_t;

    src_t rr_last;

    // Under contention the requester that was not served last goes next.
    assign loader_wins = (rr_last == SRC_FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= SRC_FETCH;
        end else if (l_gnt) begin
            rr_last <= SRC_LOADER;
        end else if (f_gnt) begin
            rr_last <= SRC_FETCH;
        end
    end
`else
    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    // Loader wins contention until fetch has been passed over MAX_WAIT times.
    assign loader_wins = (wait_cnt != MAX_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (f_gnt) begin
            wait_cnt <= 4'd0;
        end else if (f_req && (wait_cnt != MAX_CNT)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`endif

    always_comb begin
        l_gnt = l_req && (!f_req || loader_wins);
        f_gnt = f_req && !l_gnt;
    end

    always_comb begin
        if (l_gnt) begin
            m_addr  = l_addr;
            m_we    = l_we;
            m_wdata = l_wdata;
        end else begin
            m_addr  = f_addr;
            m_we    = 1'b0;
            m_wdata = '0;
        end
    end

    assign l_rd_gnt = l_gnt && !l_we;

    // Read data is captured on the grant edge; rdata holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rvalid <= 1'b0;
            f_rdata  <= '0;
            l_rvalid <= 1'b0;
            l_rdata  <= '0;
        end else begin
            f_rvalid <= f_gnt;
            l_rvalid <= l_rd_gnt;
            if (f_gnt) begin
                f_rdata <= m_rdata;
            end
            if (l_rd_gnt) begin
                l_rdata <= m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_imem_port_arb.sv
// tb/tb_imem_port_arb.sv - directed self-checking bench for imem_port_arb
// The bench models the combinational-read memory; expectations follow IMEM_ARB_RR_EN.
module tb_imem_port_arb;

    logic        clk;
    logic        rst_n;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        l_req;
    logic        l_we;
    logic [15:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_gnt;
    logic        l_rvalid;
    logic [31:0] l_rdata;
    logic [15:0] m_addr;
    logic        m_we;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    logic [31:0] mem [256];

    int errors = 0;
    int checks = 0;

    imem_port_arb #(.AW(16), .DW(32), .MAX_WAIT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .l_req    (l_req),
        .l_we     (l_we),
        .l_addr   (l_addr),
        .l_wdata  (l_wdata),
        .l_gnt    (l_gnt),
        .l_rvalid (l_rvalid),
        .l_rdata  (l_rdata),
        .m_addr   (m_addr),
        .m_we     (m_we),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign m_rdata = mem[m_addr[7:0]];

    always @(posedge clk) begin
        if (m_we) mem[m_addr[7:0]] <= m_wdata;
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where registered outputs are stable.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        f_req   = 1'b0;
        f_addr  = '0;
        l_req   = 1'b0;
        l_we    = 1'b0;
        l_addr  = '0;
        l_wdata = '0;
        next_cycle();
        next_cycle();
        check("rst_f_rvalid", {31'd0, f_rvalid}, 32'd0);
        check("rst_l_rvalid", {31'd0, l_rvalid}, 32'd0);
        check("rst_f_rdata", f_rdata, 32'd0);
        check("rst_l_rdata", l_rdata, 32'd0);
        rst_n = 1'b1;

        // Fetch alone on consecutive addresses.
        for (int i = 0; i < 3; i++) begin
            f_req  = 1'b1;
            f_addr = 16'(i);
            #4;
            check("fa_f_gnt", {31'd0, f_gnt}, 32'd1);
            check("fa_l_gnt", {31'd0, l_gnt}, 32'd0);
            check("fa_m_addr", {16'd0, m_addr}, i);
            check("fa_m_we", {31'd0, m_we}, 32'd0);
            check("fa_m_wdata", m_wdata, 32'd0);
            next_cycle();
            check("fa_f_rvalid", {31'd0, f_rvalid}, 32'd1);
            check("fa_f_rdata", f_rdata, 32'h1000_0000 + i);
        end
        f_req = 1'b0;
        #4;
        check("idle_f_gnt", {31'd0, f_gnt}, 32'd0);
        check("idle_l_gnt", {31'd0, l_gnt}, 32'd0);
        next_cycle();
        check("idle_f_rvalid", {31'd0, f_rvalid}, 32'd0);
        check("hold_f_rdata", f_rdata, 32'h1000_0002);

        // Loader write then read back.
        l_req = 1'b1; l_we = 1'b1; l_addr = 16'h0005; l_wdata = 32'hDEAD_BEEF;
        #4;
        check("lw_l_gnt", {31'd0, l_gnt}, 32'd1);
        check("lw_m_we", {31'd0, m_we}, 32'd1);
        check("lw_m_addr", {16'd0, m_addr}, 32'h5);
        check("lw_m_wdata", m_wdata, 32'hDEAD_BEEF);
        next_cycle();
        l_req = 1'b0; l_we = 1'b0;
        check("lw_l_rvalid", {31'd0, l_rvalid}, 32'd0);
        #4;
        check("lw_m_we_off", {31'd0, m_we}, 32'd0);
        next_cycle();
        l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0005;
        #4;
        check("lr_l_gnt", {31'd0, l_gnt}, 32'd1);
        next_cycle();
        l_req = 1'b0;
        check("lr_l_rvalid", {31'd0, l_rvalid}, 32'd1);
        check("lr_l_rdata", l_rdata, 32'hDEAD_BEEF);
        next_cycle();
        check("lr_l_rvalid_off", {31'd0, l_rvalid}, 32'd0);
        check("lr_l_rdata_hold", l_rdata, 32'hDEAD_BEEF);

        // Loader write followed by fetch of the same word.
        l_req = 1'b1; l_we = 1'b1; l_addr = 16'h0003; l_wdata = 32'h0000_0020;
        next_cycle();
        l_req = 1'b0; l_we = 1'b0;
        f_req = 1'b1; f_addr = 16'h0003;
        #4;
        check("wf_f_gnt", {31'd0, f_gnt}, 32'd1);
        next_cycle();
        f_req = 1'b0;
        check("wf_f_rvalid", {31'd0, f_rvalid}, 32'd1);
        check("wf_f_rdata", f_rdata, 32'h0000_0020);
        next_cycle();

        // Contention with both requesters held high; loader wins first in either mode.
        f_req = 1'b1; f_addr = 16'h0008;
        l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0007;
        for (int c = 0; c < 10; c++) begin
            logic exp_f;
`ifdef IMEM_ARB_RR_EN
            exp_f = (c % 2) == 1;
`else
            exp_f = (c % 5) == 4;
`endif
            #4;
            check($sformatf("ct_f_gnt_%0d", c), {31'd0, f_gnt}, {31'd0, exp_f});
            check($sformatf("ct_l_gnt_%0d", c), {31'd0, l_gnt}, {31'd0, !exp_f});
            next_cycle();
            check($sformatf("ct_f_rvalid_%0d", c), {31'd0, f_rvalid}, {31'd0, exp_f});
            check($sformatf("ct_l_rvalid_%0d", c), {31'd0, l_rvalid}, {31'd0, !exp_f});
            if (exp_f) check("ct_f_rdata", f_rdata, 32'h1000_0008);
            else       check("ct_l_rdata", l_rdata, 32'h1000_0007);
        end

`ifndef IMEM_ARB_RR_EN
        // Wait count holds while fetch is idle: 2 losses, idle cycle, then 2 more losses before fetch wins.
        for (int c = 0; c < 6; c++) begin
            logic exp_f;
            f_req = (c != 2);
            exp_f = (c == 5);
            #4;
            check($sformatf("wh_f_gnt_%0d", c), {31'd0, f_gnt}, {31'd0, exp_f});
            check($sformatf("wh_l_gnt_%0d", c), {31'd0, l_gnt}, {31'd0, !exp_f});
            next_cycle();
        end
`endif
        l_req = 1'b0;
        f_req = 1'b0;
        next_cycle();

        // Asynchronous reset with a fetch read response outstanding.
        f_req = 1'b1; f_addr = 16'h0001;
        next_cycle();
        f_req = 1'b0;
        check("ar_pre_f_rvalid", {31'd0, f_rvalid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_f_rvalid", {31'd0, f_rvalid}, 32'd0);
        check("ar_l_rvalid", {31'd0, l_rvalid}, 32'd0);
        check("ar_f_rdata", f_rdata, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        check("ar_post_f_rvalid", {31'd0, f_rvalid}, 32'd0);
        check("ar_post_l_rvalid", {31'd0, l_rvalid}, 32'd0);
        next_cycle();
        check("ar_post2_f_rvalid", {31'd0, f_rvalid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
